branch_unit: RTL and testbench
==============================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 4, number of return-address stack entries (power of two, 2..16).
REQ-002 SHALL have parameter LUT_DEPTH, default 32, number of 12-bit jump-target table entries.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-004 SHALL have port init  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port halt  input  1  processor halted; freezes this block.
REQ-006 SHALL have port pc  input  12  PC of the instruction currently executing.
REQ-007 SHALL have port op  input  3  branch opcode: 0 NONE, 1 BEQZ, 2 BNEZ, 3 JMP, 4 CALL, 5 RET, 6-7 treated as NONE.
REQ-008 SHALL have port zero  input  1  ALU zero flag for BEQZ/BNEZ.
REQ-009 SHALL have port imm  input  8  signed relative offset (BEQZ/BNEZ) or LUT index in imm[4:0] (JMP/CALL).
REQ-010 SHALL have ports lut_we  input  1, lut_addr  input  5, lut_wdata  input  12: jump-table write port.
REQ-011 SHALL have port branch_en  output  1  redirect PC this cycle.
REQ-012 SHALL have port target  output  12  redirect address, valid when branch_en=1.
REQ-013 SHALL have ports stk_ovf  output  1 and stk_unf  output  1: sticky stack overflow/underflow flags.
REQ-014 SHALL have port taken_cnt  output  16  count of taken redirects.

Function
REQ-015 branch_en and target SHALL be combinational from current inputs and registered state, so the PC consumes them at the same edge (zero-cycle latency).
REQ-016 BEQZ SHALL assert branch_en iff zero=1; BNEZ iff zero=0; target = pc + sign-extended imm, modulo 2^12 (wrap-around, no error).
REQ-017 JMP SHALL assert branch_en unconditionally with target = lut[imm[4:0]].
REQ-018 CALL SHALL assert branch_en with target = lut[imm[4:0]] and push (pc+1) mod 2^12 onto the stack at the edge.
REQ-019 RET with non-empty stack SHALL assert branch_en, target = top-of-stack, and pop at the edge.
REQ-020 RET with empty stack SHALL hold branch_en=0, leave stack unchanged, and set stk_unf at the edge.
REQ-021 CALL with full stack (STACK_DEPTH entries) SHALL still branch, SHALL NOT modify the stack, and SHALL set stk_ovf at the edge.
REQ-022 Stack SHALL be LIFO with a pointer 0..STACK_DEPTH; empty when 0, full when STACK_DEPTH.
REQ-023 NONE/reserved opcodes SHALL hold branch_en=0 and target=0.
REQ-024 lut_we=1 SHALL write lut_wdata to lut[lut_addr] at the edge; a same-cycle JMP/CALL to that index SHALL use the old value.
REQ-025 LUT writes SHALL occur regardless of halt; all other state SHALL freeze while halt=1.
REQ-026 halt=1 SHALL force branch_en=0 and target=0 combinationally.
REQ-027 taken_cnt SHALL increment at every edge where branch_en=1, saturating at 16'hFFFF.
REQ-028 stk_ovf/stk_unf SHALL remain set until init.

Reset
REQ-029 init=1 at an edge SHALL clear stack pointer, all stack entries, all LUT entries, stk_ovf, stk_unf and taken_cnt to 0, overriding any same-cycle op or lut_we.
REQ-030 While init=1, branch_en SHALL be 0; init mid-CALL/RET SHALL discard that push/pop.

Verification
REQ-031 Write lut[3]=12'h040, then pc=12'h010, op=CALL, imm=3 -> branch_en=1, target=12'h040; next cycle pc=12'h050, op=RET -> target=12'h011, stack empty after.
REQ-032 pc=12'h005, op=BEQZ, imm=8'hF0, zero=1 -> target=12'hFF5 (wrap); same with zero=0 -> branch_en=0.
REQ-033 Five CALLs with STACK_DEPTH=4 -> fifth branches, stk_ovf=1; four RETs return the four pushed addresses in reverse order; fifth RET -> branch_en=0, stk_unf=1.
REQ-034 Same cycle lut_we=1, lut_addr=7, lut_wdata=12'h123 with op=JMP, imm=7 (old 12'h000) -> target=12'h000; next JMP imm=7 -> 12'h123.
REQ-035 halt=1 with op=CALL -> branch_en=0, stack and taken_cnt unchanged; init=1 with op=CALL -> all state zero next cycle.
REQ-036 Force taken_cnt to 16'hFFFE via 65534 JMPs, two more JMPs -> taken_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/branch_unit.sv
// branch_unit
//   Resolves branch/jump/call/return redirects for a small sequencer core.
//   The redirect (branch_en/target) is combinational so the PC register
//   consumes it at the same edge the instruction executes.  Holds a
//   12-bit jump-target table and a LIFO return-address stack.
//
// Ports
//   CLK        sole clock, all state updates on posedge
//   init       synchronous active-high reset
//   halt       freezes everything except jump-table writes
//   pc         PC of the executing instruction
//   op         0 NONE, 1 BEQZ, 2 BNEZ, 3 JMP, 4 CALL, 5 RET, 6-7 NONE
//   zero       ALU zero flag for BEQZ/BNEZ
//   imm        signed PC-relative offset, or table index in imm[4:0]
//   lut_we/lut_addr/lut_wdata  jump-table write port
//   branch_en  redirect PC this cycle
//   target     redirect address (0 when branch_en=0)
//   stk_ovf    sticky: CALL attempted on a full stack
//   stk_unf    sticky: RET attempted on an empty stack
//   taken_cnt  saturating count of taken redirects

module branch_unit #(
    parameter int STACK_DEPTH = 4,
    parameter int LUT_DEPTH   = 32
) (
    input  logic        CLK,
    input  logic        init,
    input  logic        halt,
    input  logic [11:0] pc,
    input  logic [2:0]  op,
    input  logic        zero,
    input  logic [7:0]  imm,
    input  logic        lut_we,
    input  logic [4:0]  lut_addr,
    input  logic [11:0] lut_wdata,
    output logic        branch_en,
    output logic [11:0] target,
    output logic        stk_ovf,
    output logic        stk_unf,
    output logic [15:0] taken_cnt
);

    // Pointer needs one extra bit so it can hold STACK_DEPTH (full).
    localparam int PW = $clog2(STACK_DEPTH) + 1;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_BEQZ = 3'd1,
        OP_BNEZ = 3'd2,
        OP_JMP  = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5
    } op_e;

    logic [11:0]   lut_q [LUT_DEPTH];
    logic [11:0]   lut_d [LUT_DEPTH];
    logic [11:0]   stk_q [STACK_DEPTH];
    logic [11:0]   stk_d [STACK_DEPTH];
    logic [PW-1:0] sp_q, sp_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [15:0]   cnt_q, cnt_d;

    logic [11:0]   lut_rd;
    logic [11:0]   tos;
    logic [11:0]   rel_tgt;
    logic          stk_empty;
    logic          stk_full;
    logic          do_push;
    logic          do_pop;
    logic          set_ovf;
    logic          set_unf;

    // Table and stack reads are decoded with compares rather than direct
    // indexing so out-of-range indices simply read as 0.
    always_comb begin
        lut_rd = '0;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            if (imm[4:0] == 5'(i)) lut_rd = lut_q[i];
        end
    end

    always_comb begin
        tos = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == PW'(i + 1)) tos = stk_q[i];
        end
    end

    assign stk_empty = (sp_q == '0);
    assign stk_full  = (sp_q == PW'(STACK_DEPTH));
    assign rel_tgt   = pc + {{4{imm[7]}}, imm};

    always_comb begin
        branch_en = 1'b0;
        target    = '0;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        if (!init && !halt) begin
            case (op)
                OP_BEQZ: begin
                    if (zero) begin
                        branch_en = 1'b1;
                        target    = rel_tgt;
                    end
                end
                OP_BNEZ: begin
                    if (!zero) begin
                        branch_en = 1'b1;
                        target    = rel_tgt;
                    end
                end
                OP_JMP: begin
                    branch_en = 1'b1;
                    target    = lut_rd;
                end
                OP_CALL: begin
                    // A full stack still redirects; only the push is lost.
                    branch_en = 1'b1;
                    target    = lut_rd;
                    if (stk_full) set_ovf = 1'b1;
                    else          do_push = 1'b1;
                end
                OP_RET: begin
                    if (stk_empty) begin
                        set_unf = 1'b1;
                    end else begin
                        branch_en = 1'b1;
                        target    = tos;
                        do_pop    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        lut_d = lut_q;
        // Table writes ignore halt so firmware can preload while stalled.
        if (lut_we) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                if (lut_addr == 5'(i)) lut_d[i] = lut_wdata;
            end
        end

        stk_d = stk_q;
        sp_d  = sp_q;
        if (do_push) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (sp_q == PW'(i)) stk_d[i] = pc + 12'd1;
            end
            sp_d = sp_q + PW'(1);
        end else if (do_pop) begin
            sp_d = sp_q - PW'(1);
        end

        ovf_d = ovf_q | set_ovf;
        unf_d = unf_q | set_unf;
        cnt_d = (branch_en && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (init) begin
            lut_q <= '{default: '0};
            stk_q <= '{default: '0};
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            lut_q <= lut_d;
            stk_q <= stk_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            cnt_q <= cnt_d;
        end
    end

    assign stk_ovf   = ovf_q;
    assign stk_unf   = unf_q;
    assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit
//   Directed-vector bench for branch_unit.  Inputs change on the falling
//   edge; outputs are compared 1 ns later, before the next rising edge.

module tb_branch_unit;

    localparam logic [2:0] NONE = 3'd0, BEQZ = 3'd1, BNEZ = 3'd2,
                           JMP  = 3'd3, CALL = 3'd4, RET  = 3'd5;

    logic        CLK = 1'b0;
    logic        init, halt, zero, lut_we;
    logic [11:0] pc, lut_wdata, target;
    logic [2:0]  op;
    logic [7:0]  imm;
    logic [4:0]  lut_addr;
    logic        branch_en, stk_ovf, stk_unf;
    logic [15:0] taken_cnt;

    int tests = 0;
    int fails = 0;

    branch_unit #(.STACK_DEPTH(4), .LUT_DEPTH(32)) dut (
        .CLK       (CLK),
        .init      (init),
        .halt      (halt),
        .pc        (pc),
        .op        (op),
        .zero      (zero),
        .imm       (imm),
        .lut_we    (lut_we),
        .lut_addr  (lut_addr),
        .lut_wdata (lut_wdata),
        .branch_en (branch_en),
        .target    (target),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf),
        .taken_cnt (taken_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle's inputs at the falling edge, settle, return.
    task automatic cyc(input logic i_init, input logic i_halt,
                       input logic [11:0] i_pc, input logic [2:0] i_op,
                       input logic i_zero, input logic [7:0] i_imm,
                       input logic i_we, input logic [4:0] i_addr,
                       input logic [11:0] i_wdata);
        @(negedge CLK);
        init = i_init; halt = i_halt; pc = i_pc; op = i_op; zero = i_zero;
        imm = i_imm; lut_we = i_we; lut_addr = i_addr; lut_wdata = i_wdata;
        #1;
    endtask

    task automatic br(input string tag, input logic be, input logic [11:0] tg);
        check({tag, ".en"}, 32'(branch_en), 32'(be));
        check({tag, ".tgt"}, 32'(target), 32'(tg));
    endtask

    initial begin
        init = 1; halt = 0; pc = 0; op = NONE; zero = 0; imm = 0;
        lut_we = 0; lut_addr = 0; lut_wdata = 0;

        // Reset, with a CALL pending while init is high
        cyc(1, 0, 12'h010, CALL, 0, 8'd3, 1, 5'd3, 12'hABC);
        br("init_call", 0, 12'h000);
        cyc(1, 0, 12'h010, CALL, 0, 8'd3, 1, 5'd3, 12'hABC);
        cyc(0, 0, 12'h000, NONE, 0, 8'd0, 1, 5'd3, 12'h040);
        br("none", 0, 12'h000);
        check("rst_ovf", 32'(stk_ovf), 0);
        check("rst_unf", 32'(stk_unf), 0);
        check("rst_cnt", 32'(taken_cnt), 0);

        // CALL / RET round trip
        cyc(0, 0, 12'h010, CALL, 0, 8'd3, 0, 5'd0, 12'h000);
        br("call", 1, 12'h040);
        cyc(0, 0, 12'h050, RET, 0, 8'd0, 0, 5'd0, 12'h000);
        br("ret", 1, 12'h011);
        check("cnt_1", 32'(taken_cnt), 1);
        cyc(0, 0, 12'h051, RET, 0, 8'd0, 0, 5'd0, 12'h000);
        br("ret_empty", 0, 12'h000);
        cyc(0, 0, 12'h000, NONE, 0, 8'd0, 0, 5'd0, 12'h000);
        check("unf_set", 32'(stk_unf), 1);
        check("cnt_2", 32'(taken_cnt), 2);
        cyc(0, 0, 12'h000, 3'd7, 0, 8'd0, 0, 5'd0, 12'h000);
        br("reserved7", 0, 12'h000);
        check("unf_sticky", 32'(stk_unf), 1);

        // Relative branches with wrap-around
        cyc(0, 0, 12'h005, BEQZ, 1, 8'hF0, 0, 5'd0, 12'h000);
        br("beqz_z1", 1, 12'hFF5);
        cyc(0, 0, 12'h005, BEQZ, 0, 8'hF0, 0, 5'd0, 12'h000);
        br("beqz_z0", 0, 12'h000);
        cyc(0, 0, 12'hFFE, BNEZ, 0, 8'h05, 0, 5'd0, 12'h000);
        br("bnez_z0", 1, 12'h003);
        cyc(0, 0, 12'hFFE, BNEZ, 1, 8'h05, 0, 5'd0, 12'h000);
        br("bnez_z1", 0, 12'h000);

        // Overflow: five CALLs into a 4-deep stack
        cyc(0, 0, 12'h000, NONE, 0, 8'd0, 1, 5'd1, 12'h100);
        check("cnt_4", 32'(taken_cnt), 4);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 12'(12'h020 + 12'h010 * i), CALL, 0, 8'd1, 0, 5'd0, 12'h000);
            br($sformatf("ovf_call%0d", i), 1, 12'h100);
            check($sformatf("ovf_before%0d", i), 32'(stk_ovf), 0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 12'h200, RET, 0, 8'd0, 0, 5'd0, 12'h000);
            br($sformatf("ovf_ret%0d", i), 1, 12'(12'h051 - 12'h010 * i));
            check($sformatf("ovf_flag%0d", i), 32'(stk_ovf), 1);
        end
        cyc(0, 0, 12'h200, RET, 0, 8'd0, 0, 5'd0, 12'h000);
        br("ovf_ret4", 0, 12'h000);
        cyc(0, 0, 12'h000, NONE, 0, 8'd0, 0, 5'd0, 12'h000);
        check("ovf_unf", 32'(stk_unf), 1);
        check("ovf_sticky", 32'(stk_ovf), 1);
        check("cnt_13", 32'(taken_cnt), 13);

        // init clears flags, counter and the table
        cyc(1, 0, 12'h000, NONE, 0, 8'd0, 0, 5'd0, 12'h000);
        cyc(0, 0, 12'h000, JMP, 0, 8'd3, 0, 5'd0, 12'h000);
        br("lut_cleared", 1, 12'h000);
        check("clr_ovf", 32'(stk_ovf), 0);
        check("clr_unf", 32'(stk_unf), 0);
        check("clr_cnt", 32'(taken_cnt), 0);

        // Same-cycle write and JMP reads old entry
        cyc(0, 0, 12'h000, JMP, 0, 8'd7, 1, 5'd7, 12'h123);
        br("jmp_old", 1, 12'h000);
        cyc(0, 0, 12'h000, JMP, 0, 8'd7, 0, 5'd0, 12'h000);
        br("jmp_new", 1, 12'h123);

        // halt: redirect and stack frozen, table writes still land
        cyc(0, 0, 12'h080, CALL, 0, 8'd7, 0, 5'd0, 12'h000);
        br("pre_halt_call", 1, 12'h123);
        cyc(0, 1, 12'h070, CALL, 0, 8'd7, 1, 5'd2, 12'h0AB);
        br("halt_call", 0, 12'h000);
        check("halt_cnt_a", 32'(taken_cnt), 4);
        cyc(0, 1, 12'h070, RET, 0, 8'd0, 0, 5'd0, 12'h000);
        br("halt_ret", 0, 12'h000);
        check("halt_cnt_b", 32'(taken_cnt), 4);
        cyc(0, 0, 12'h000, JMP, 0, 8'd2, 0, 5'd0, 12'h000);
        br("halt_lutwr", 1, 12'h0AB);
        cyc(0, 0, 12'h090, RET, 0, 8'd0, 0, 5'd0, 12'h000);
        br("halt_stk", 1, 12'h081);
        cyc(0, 0, 12'h090, RET, 0, 8'd0, 0, 5'd0, 12'h000);
        br("halt_stk_empty", 0, 12'h000);

        // init overriding a CALL
        cyc(0, 0, 12'h0A0, CALL, 0, 8'd2, 0, 5'd0, 12'h000);
        cyc(1, 0, 12'h0B0, CALL, 0, 8'd2, 1, 5'd4, 12'h555);
        br("init_ovr", 0, 12'h000);
        cyc(0, 0, 12'h000, RET, 0, 8'd0, 0, 5'd0, 12'h000);
        br("init_ret", 0, 12'h000);
        check("init_cnt", 32'(taken_cnt), 0);
        cyc(0, 0, 12'h000, JMP, 0, 8'd4, 0, 5'd0, 12'h000);
        br("init_lutwr", 1, 12'h000);

        // Saturation: counter is 1 after the JMP above
        cyc(1, 0, 12'h000, NONE, 0, 8'd0, 0, 5'd0, 12'h000);
        for (int i = 0; i < 65534; i++)
            cyc(0, 0, 12'h000, JMP, 0, 8'd0, 0, 5'd0, 12'h000);
        cyc(0, 0, 12'h000, NONE, 0, 8'd0, 0, 5'd0, 12'h000);
        check("sat_fffe", 32'(taken_cnt), 32'hFFFE);
        cyc(0, 0, 12'h000, JMP, 0, 8'd0, 0, 5'd0, 12'h000);
        cyc(0, 0, 12'h000, JMP, 0, 8'd0, 0, 5'd0, 12'h000);
        check("sat_ffff_a", 32'(taken_cnt), 32'hFFFF);
        cyc(0, 0, 12'h000, NONE, 0, 8'd0, 0, 5'd0, 12'h000);
        check("sat_ffff_b", 32'(taken_cnt), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
